// File: rtl/stage_share_arb_if.sv
// Handshake bundle for stage_share_arb.
//   req_*  : per-requester operand request (valid/ready, two operand bits each)
//   stg_*  : launch strobe and operands to the shared stage chain, plus its results
//   rsp_*  : per-requester held result (valid/ready, two result bits each)
//   hold   : request to stop launching and drain the chain
//   paused : chain fully drained and launching stopped
// The slave modport is the arbiter side; master is the surrounding environment.
interface stage_share_arb_if #(
    parameter int unsigned NREQ = 6
);
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_i1;
    logic [NREQ-1:0] req_i2;
    logic [NREQ-1:0] req_ready;
    logic            stg_valid;
    logic            stg_I1;
    logic            stg_I2;
    logic            stg_O1;
    logic            stg_O2;
    logic [NREQ-1:0] rsp_valid;
    logic [NREQ-1:0] rsp_o1;
    logic [NREQ-1:0] rsp_o2;
    logic [NREQ-1:0] rsp_ready;
    logic            hold;
    logic            paused;

    modport slave (
        input  req_valid, req_i1, req_i2, stg_O1, stg_O2, rsp_ready, hold,
        output req_ready, stg_valid, stg_I1, stg_I2, rsp_valid, rsp_o1, rsp_o2, paused
    );

    modport master (
        output req_valid, req_i1, req_i2, stg_O1, stg_O2, rsp_ready, hold,
        input  req_ready, stg_valid, stg_I1, stg_I2, rsp_valid, rsp_o1, rsp_o2, paused
    );
endinterface

// File: rtl/stage_share_arb.sv
// Round-robin arbiter sharing one fixed-latency 2-bit stage chain among NREQ requesters.
// Each requester may have one operation outstanding; its result is held in a per-requester
// response slot until accepted. A hold request drains the chain and then pauses launching.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : stage_share_arb_if.slave (request, stage-chain and response handshakes, hold/paused)
module stage_share_arb #(
    parameter int unsigned NREQ = 6,
    parameter int unsigned LAT  = 3
) (
    input logic              clk,
    input logic              rst,
    stage_share_arb_if.slave bus
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StRun, StDrain, StPaused} state_e;

    state_e          state_q;
    logic            paused_q;
    logic [PW-1:0]   ptr_q;
    logic [NREQ-1:0] busy_q;

    // Launch register: stage 0 of the operation, drives the chain inputs.
    logic            stg_valid_q;
    logic            stg_i1_q;
    logic            stg_i2_q;
    logic [PW-1:0]   stg_k_q;

    // Tag pipeline: the last stage lines up with the chain result.
    logic [LAT-1:0]  tag_valid_q;
    logic [PW-1:0]   tag_k_q [LAT];

    logic [NREQ-1:0] rsp_valid_q;
    logic [NREQ-1:0] rsp_o1_q;
    logic [NREQ-1:0] rsp_o2_q;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant_vec;
    logic            grant_found;
    logic [PW-1:0]   grant_idx;
    logic [PW-1:0]   cand;
    logic [PW-1:0]   ptr_d;
    logic [NREQ-1:0] rsp_hs;
    logic            inflight;
    logic            cap_valid;
    logic [PW-1:0]   cap_k;

    // Eligibility depends on registered state only, so a hold seen in RUN stops
    // grants from the following (DRAIN) cycle on.
    always_comb begin
        eligible = '0;
        if (state_q == StRun && !rst) begin
            eligible = bus.req_valid & ~busy_q;
        end
    end

    // Search from ptr upwards with wrap; first eligible requester wins.
    always_comb begin
        grant_vec   = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            cand = PW'((32'(ptr_q) + 32'(i)) % NREQ);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        if (grant_found) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_found) begin
            ptr_d = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    assign rsp_hs    = rsp_valid_q & bus.rsp_ready;
    assign inflight  = stg_valid_q | (|tag_valid_q);
    assign cap_valid = tag_valid_q[LAT-1];
    assign cap_k     = tag_k_q[LAT-1];

    // Control FSM with registered paused flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRun;
            paused_q <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bus.hold) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (!bus.hold) begin
                        state_q <= StRun;
                    end else if (!inflight) begin
                        state_q  <= StPaused;
                        paused_q <= 1'b1;
                    end
                end
                StPaused: begin
                    if (!bus.hold) begin
                        state_q  <= StRun;
                        paused_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StRun;
                    paused_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            busy_q      <= '0;
            stg_valid_q <= 1'b0;
            stg_i1_q    <= 1'b0;
            stg_i2_q    <= 1'b0;
            stg_k_q     <= '0;
            tag_valid_q <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                tag_k_q[i] <= '0;
            end
            rsp_valid_q <= '0;
            rsp_o1_q    <= '0;
            rsp_o2_q    <= '0;
        end else begin
            ptr_q  <= ptr_d;
            // Grant and response handshake never hit the same requester together.
            busy_q <= (busy_q | grant_vec) & ~rsp_hs;

            stg_valid_q <= grant_found;
            stg_i1_q    <= grant_found & bus.req_i1[grant_idx];
            stg_i2_q    <= grant_found & bus.req_i2[grant_idx];
            stg_k_q     <= grant_idx;

            tag_valid_q[0] <= stg_valid_q;
            tag_k_q[0]     <= stg_k_q;
            for (int i = 1; i < int'(LAT); i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_k_q[i]     <= tag_k_q[i-1];
            end

            for (int k = 0; k < int'(NREQ); k++) begin
                if (cap_valid && cap_k == PW'(k)) begin
                    rsp_valid_q[k] <= 1'b1;
                    rsp_o1_q[k]    <= bus.stg_O1;
                    rsp_o2_q[k]    <= bus.stg_O2;
                end else if (rsp_hs[k]) begin
                    rsp_valid_q[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.req_ready = grant_vec;
    assign bus.stg_valid = stg_valid_q;
    assign bus.stg_I1    = stg_i1_q;
    assign bus.stg_I2    = stg_i2_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_o1    = rsp_o1_q;
    assign bus.rsp_o2    = rsp_o2_q;
    assign bus.paused    = paused_q;

endmodule
